// File: rtl/sync_debounce.sv
// Synchronises a raw asynchronous level into clk and rejects glitches shorter than DEBOUNCE_CYCLES.
// Emits a clean registered level, one-cycle rise/fall pulses and a wrapping count of accepted rises.
`timescale 1ns/1ps
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit RESET_VAL       = 1'b0,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             d_in,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int            DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

  state_t                 state_q;
  logic [DW-1:0]          cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_sync;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       evt_q;
  logic [CNT_W-1:0]       evt_d;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign evt_d  = evt_q + 1'b1;

  // d_in touches stage 0 only; everything downstream sees the resolved s_sync.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        STABLE: begin
          cnt_q <= '0;
          if (s_sync != level_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              level_q <= s_sync;
              rise_q  <= s_sync;
              fall_q  <= ~s_sync;
              if (s_sync) evt_q <= evt_d;
            end else begin
              state_q <= PENDING;
              busy_q  <= 1'b1;
              cnt_q   <= DW'(1);
            end
          end
        end
        PENDING: begin
          if (s_sync == level_q) begin
            state_q <= STABLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            level_q <= s_sync;
            rise_q  <= s_sync;
            fall_q  <= ~s_sync;
            if (s_sync) evt_q <= evt_d;
            state_q <= STABLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign event_cnt  = evt_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: default instance plus a DEBOUNCE_CYCLES=1 / CNT_W=2 instance on shared stimulus.
`timescale 1ns/1ps
module tb_sync_debounce;

  localparam int SYNC = 2;
  localparam bit RV   = 1'b0;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       d_in;
  logic       lv0, rp0, fp0, bz0;
  logic [7:0] ec0;
  logic       lv1, rp1, fp1, bz1;
  logic [1:0] ec1;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4), .RESET_VAL(RV), .CNT_W(8)) u0 (
    .clk(clk), .rst_l(rst_l), .d_in(d_in), .level_out(lv0), .rise_pulse(rp0),
    .fall_pulse(fp0), .busy(bz0), .event_cnt(ec0));

  sync_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1), .RESET_VAL(RV), .CNT_W(2)) u1 (
    .clk(clk), .rst_l(rst_l), .d_in(d_in), .level_out(lv1), .rise_pulse(rp1),
    .fall_pulse(fp1), .busy(bz1), .event_cnt(ec1));

  // Reference: a new level is accepted after deb[i] consecutive synchronised samples that disagree with it.
  int deb  [2] = '{4, 1};
  int cmod [2] = '{256, 4};
  bit pipe [SYNC];
  bit m_lvl [2];
  bit m_rise[2];
  bit m_fall[2];
  bit m_busy[2];
  int m_run [2];
  int m_cnt [2];

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) pipe[k] = RV;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = RV; m_rise[i] = 0; m_fall[i] = 0; m_busy[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    bit s;
    s = pipe[SYNC-1];
    for (int k = SYNC-1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = d_in;
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      m_run[i]  = (s != m_lvl[i]) ? m_run[i] + 1 : 0;
      if (m_run[i] >= deb[i]) begin
        m_lvl[i]  = s;
        m_rise[i] = s;
        m_fall[i] = !s;
        if (s) m_cnt[i] = (m_cnt[i] + 1) % cmod[i];
        m_run[i]  = 0;
      end
      m_busy[i] = (m_run[i] > 0);
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("u0.level_out",  int'(lv0), int'(m_lvl[0]));
    chk("u0.rise_pulse", int'(rp0), int'(m_rise[0]));
    chk("u0.fall_pulse", int'(fp0), int'(m_fall[0]));
    chk("u0.busy",       int'(bz0), int'(m_busy[0]));
    chk("u0.event_cnt",  int'(ec0), m_cnt[0]);
    chk("u1.level_out",  int'(lv1), int'(m_lvl[1]));
    chk("u1.rise_pulse", int'(rp1), int'(m_rise[1]));
    chk("u1.fall_pulse", int'(fp1), int'(m_fall[1]));
    chk("u1.busy",       int'(bz1), int'(m_busy[1]));
    chk("u1.event_cnt",  int'(ec1), m_cnt[1]);
  endtask

  // Every stimulus change lands at least 2 ns after a rising edge, so sampling d_in here is race-free.
  task automatic tick();
    @(posedge clk);
    if (rst_l) model_step();
    else       model_reset();
    #2;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst_l = 1'b0;
    d_in  = 1'b0;
    model_reset();
    #5;
    chk("reset level",  int'(lv0), 0);
    chk("reset busy",   int'(bz0), 0);
    chk("reset cnt",    int'(ec0), 0);
    #10 rst_l = 1'b1;

    // Idle for 200 ns.
    ticks(10);
    chk("idle level", int'(lv0), 0);
    chk("idle cnt",   int'(ec0), 0);

    // Glitches: a sub-cycle blip, then a 3-cycle pulse.
    @(posedge clk);
    model_step();
    #5 d_in = 1'b1;
    #2 d_in = 1'b0;
    #1 compare_all();
    tick();
    d_in = 1'b1;
    ticks(3);
    d_in = 1'b0;
    ticks(10);
    chk("glitch level", int'(lv0), 0);
    chk("glitch busy",  int'(bz0), 0);
    chk("glitch cnt",   int'(ec0), 0);

    // Clean rise: d_in changes just after edge N.
    d_in = 1'b1;
    ticks(2);
    chk("rise busy N+2", int'(bz0), 0);
    tick();
    chk("rise busy N+3", int'(bz0), 1);
    chk("u1 rise N+3",   int'(rp1), 1);
    ticks(2);
    chk("rise level N+5", int'(lv0), 0);
    tick();
    chk("rise level N+6", int'(lv0), 1);
    chk("rise pulse N+6", int'(rp0), 1);
    tick();
    chk("rise pulse N+7", int'(rp0), 0);
    chk("rise cnt",       int'(ec0), 1);
    ticks(3);

    // Clean fall.
    d_in = 1'b0;
    ticks(5);
    chk("fall pulse M+5", int'(fp0), 0);
    tick();
    chk("fall pulse M+6", int'(fp0), 1);
    chk("fall level M+6", int'(lv0), 0);
    tick();
    chk("fall pulse M+7", int'(fp0), 0);
    chk("fall cnt",       int'(ec0), 1);
    ticks(3);

    // Reset while qualifying a rise.
    d_in = 1'b1;
    ticks(4);
    chk("pre-reset busy", int'(bz0), 1);
    #3 rst_l = 1'b0;
    model_reset();
    #1;
    chk("async busy",   int'(bz0), 0);
    chk("async level",  int'(lv0), 0);
    chk("async cnt",    int'(ec0), 0);
    chk("async u1 lvl", int'(lv1), 0);
    #9 rst_l = 1'b1;
    ticks(5);
    chk("post-reset level R5", int'(lv0), 0);
    tick();
    chk("post-reset level R6", int'(lv0), 1);
    chk("post-reset rise R6",  int'(rp0), 1);
    chk("post-reset cnt",      int'(ec0), 1);

    // Minimum debounce and counter wrap on the CNT_W=2 instance.
    d_in = 1'b0;
    ticks(10);
    #3 rst_l = 1'b0;
    model_reset();
    #5 rst_l = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      d_in = 1'b1;
      ticks(2);
      chk("wrap level E+2", int'(lv1), 0);
      tick();
      chk("wrap rise E+3", int'(rp1), 1);
      chk("wrap cnt",      int'(ec1), wrap_exp[j]);
      d_in = 1'b0;
      ticks(9);
    end

    // Randomised runs, with sub-cycle glitches and occasional mid-cycle resets.
    for (int r = 0; r < 2000; r++) begin
      bit lvl;
      int hold;
      lvl  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 10);
      for (int h = 0; h < hold; h++) begin
        tick();
        #($urandom_range(0, 10));
        d_in = lvl;
        if ($urandom_range(0, 7) == 0) begin
          #1 d_in = ~d_in;
          #2 d_in = ~d_in;
        end
        if ($urandom_range(0, 199) == 0) begin
          #1 rst_l = 1'b0;
          model_reset();
          #1 compare_all();
          #1 rst_l = 1'b1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
